key_event_decoder: RTL
======================

# key_event_decoder

Consumes the debounced, active-low key level from the key debouncer and classifies each key gesture into one-cycle event pulses: short press, long press and double click, plus optional auto-repeat while held. It is the consumer end of the debounced-key interface: it sits between the debouncer and application logic such as mode switches and counters. The input is already synchronous to `sys_clk` and glitch-free.

## Interface
- `LONG_TIME`, 26'd49_999_999: hold count for a long press (1 s at 50 MHz).
- `GAP_TIME`, 26'd12_499_999: maximum release gap for a double click (250 ms).
- `REPEAT_TIME`, 26'd4_999_999: auto-repeat period while held (100 ms).
- `CNT_W`, 26: counter width. Must hold all three times; elaboration error otherwise.

Ports:
- `sys_clk` in 1: system clock, 50 MHz.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `key_in` in 1: debounced key, 1 = released, 0 = pressed.
- `short_pulse` out 1: one-cycle single short press event.
- `long_pulse` out 1: one-cycle long press event.
- `double_pulse` out 1: one-cycle double click event.
- `repeat_pulse` out 1: one-cycle auto-repeat event. Constant 0 without the macro.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- All outputs and internal state are registered.
- Edge register `key_d` resets to 1. A press is detected when `key_d & ~key_in`.
- One shared counter `cnt` (CNT_W bits). It clears on every state entry.
- States:
  - IDLE: on press detected → PRESS1.
  - PRESS1: `key_in`=1 → WAIT_GAP. Else if `cnt==LONG_TIME` → assert `long_pulse`, go to HOLD. Else `cnt++`.
  - WAIT_GAP: `key_in`=0 → PRESS2. Else if `cnt==GAP_TIME` → assert `short_pulse`, go to IDLE. Else `cnt++`.
  - PRESS2: `key_in`=1 → assert `double_pulse`, go to IDLE. There is no long detection on the second press.
  - HOLD: `key_in`=1 → IDLE. Otherwise, with the macro enabled, repeat counting applies (see Configuration).
- Boundary rules:
  - PRESS1: release on the same edge as `cnt==LONG_TIME` means release wins. The result is WAIT_GAP and no long event.
  - WAIT_GAP: press on the same edge as `cnt==GAP_TIME` means the press wins. The result is PRESS2 and no short event.
  - Exactly one event of short/long/double is emitted per gesture. Pulses never overlap.
  - Counter never wraps. It is compared and cleared before it can exceed its time.
  - Reset mid-gesture: returns to IDLE and clears all pulses. The key must be released and pressed again to produce an event.

## Timing
- Reset values: `short_pulse`=`long_pulse`=`double_pulse`=`repeat_pulse`=0, `busy`=0, `key_d`=1, state IDLE, `cnt`=0.
- E0 is the edge at which the press is detected. `busy` is high after E0.
- `long_pulse` is high for the cycle after edge E0+LONG_TIME+1.
- Er is the release edge in PRESS1. `short_pulse` is high after edge Er+GAP_TIME+1.
- `double_pulse` is high after the release edge in PRESS2. `busy` is low from that same edge.
- All pulses are exactly one cycle wide.

## Configuration
- `KEY_EVENT_REPEAT_EN` defined:
  - In HOLD, each edge with `key_in`=0: if `cnt==REPEAT_TIME`, assert `repeat_pulse` and clear `cnt`; else `cnt++`.
  - The first repeat pulse follows edge E0+LONG_TIME+REPEAT_TIME+2. Subsequent pulses follow every REPEAT_TIME+1 cycles.
- Not defined:
  - `repeat_pulse` is tied 0.
  - HOLD only waits for release.
  - The port list is unchanged.

## Structure
- Shared package `key_event_pkg`:
  - state enum (IDLE, PRESS1, WAIT_GAP, PRESS2, HOLD);
  - default time constants for 50 MHz.
- One sub-module, `key_edge_detect`: holds `key_d` and emits the one-cycle press/release strobes.
- The FSM and counter stay in the top module.

## Test plan
All scenarios use LONG_TIME=20, GAP_TIME=10, REPEAT_TIME=5.
1. Low 5 cycles then high → `short_pulse` one cycle after edge Er+11. No other pulses. `busy` drops with the pulse.
2. Low 40 cycles, macro off → `long_pulse` after edge E0+21. No pulse at release. No short afterwards.
3. Low 5, high 4, low 5, high → `double_pulse` one cycle after the second release edge. No `short_pulse`.
4. Second press landing exactly on the `cnt==GAP_TIME` edge → `double_pulse` on its release. `short_pulse` never asserts.
5. `sys_rst_n` pulsed low at cnt=12 in PRESS1 while the key is held:
   - all outputs are 0 and no event follows;
   - after release and re-press, `long_pulse` follows the full E0+21.
6. Macro on, low 40 cycles → `long_pulse` after E21; `repeat_pulse` after E27, E33, E39. With the macro off, the same stimulus produces no repeats.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared state encoding and 50 MHz default timings for the key event decoder.
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    PRESS2,
    HOLD
  } key_state_e;

  localparam int unsigned LONG_TIME_DEF   = 49_999_999;  // 1 s
  localparam int unsigned GAP_TIME_DEF    = 12_499_999;  // 250 ms
  localparam int unsigned REPEAT_TIME_DEF = 4_999_999;   // 100 ms
  localparam int unsigned CNT_W_DEF       = 26;

endpackage

// File: rtl/key_edge_detect.sv
// Press/release strobes from the debounced active-low key level.
module key_edge_detect (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic press_stb,
  output logic rel_stb
);

  logic key_d;
  logic armed;

  // armed blocks a key that is still held across reset from counting as a press
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_d <= 1'b1;
      armed <= 1'b0;
    end else begin
      key_d <= key_in;
      armed <= armed | key_in;
    end
  end

  assign press_stb = armed & key_d & ~key_in;
  assign rel_stb   = ~key_d & key_in;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures into short/long/double (and repeat) pulses.
// Define KEY_EVENT_REPEAT_EN to enable auto-repeat pulses while a long press is held.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_TIME   = LONG_TIME_DEF,
  parameter int unsigned GAP_TIME    = GAP_TIME_DEF,
  parameter int unsigned REPEAT_TIME = REPEAT_TIME_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (64'(LONG_TIME) > CNT_MAX || 64'(GAP_TIME) > CNT_MAX ||
      64'(REPEAT_TIME) > CNT_MAX) begin : g_cnt_w_check
    $error("key_event_decoder: CNT_W too narrow for the configured times");
  end

  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_TIME);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_TIME);
`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_TIME);
`endif

  key_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_stb, rel_stb;
  logic             short_nxt, long_nxt, dbl_nxt, rpt_nxt;

  key_edge_detect u_edge (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .press_stb (press_stb),
    .rel_stb   (rel_stb)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      short_pulse  <= short_nxt;
      long_pulse   <= long_nxt;
      double_pulse <= dbl_nxt;
      repeat_pulse <= rpt_nxt;
      busy         <= (state_nxt != IDLE);
    end
  end

  // Key is low throughout PRESS1/PRESS2/HOLD and high throughout WAIT_GAP, so
  // the edge strobes are equivalent to testing the key level in those states.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    dbl_nxt   = 1'b0;
    rpt_nxt   = 1'b0;
    case (state)
      IDLE:     if (press_stb) state_nxt = PRESS1;
      PRESS1: begin
        if (rel_stb) state_nxt = WAIT_GAP;
        else if (cnt == LONG_C) begin
          long_nxt  = 1'b1;
          state_nxt = HOLD;
        end else cnt_nxt = cnt + CNT_W'(1);
      end
      WAIT_GAP: begin
        if (press_stb) state_nxt = PRESS2;
        else if (cnt == GAP_C) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
        end else cnt_nxt = cnt + CNT_W'(1);
      end
      PRESS2: begin
        if (rel_stb) begin
          dbl_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (rel_stb) state_nxt = IDLE;
`ifdef KEY_EVENT_REPEAT_EN
        else if (cnt == REP_C) begin
          rpt_nxt = 1'b1;
          cnt_nxt = '0;
        end else cnt_nxt = cnt + CNT_W'(1);
`endif
      end
      default:  state_nxt = IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

endmodule
